// File: rtl/present_pkg.sv
// Shared types and sizes for the PRESENT-80 round sequencer.
package present_pkg;

  localparam int PRESENT_ROUNDS = 31;
  localparam int BLK_W          = 64;
  localparam int KEY_W          = 80;
  localparam int CNT_W          = 5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    FIN  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/present_round_cnt.sv
// Round counter: clear has priority over load-1, which has priority over increment.
// Saturates at ROUNDS so values beyond the last round never occur.
module present_round_cnt
  import present_pkg::*;
#(
  parameter int ROUNDS = PRESENT_ROUNDS,
  parameter int RND_W  = CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             ld1,
  input  logic             inc,
  output logic [RND_W-1:0] cnt,
  output logic             last
);

  assign last = (cnt == RND_W'(ROUNDS));

  // counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             cnt <= '0;
    else if (clr)           cnt <= '0;
    else if (ld1)           cnt <= RND_W'(1);
    else if (inc && !last)  cnt <= cnt + RND_W'(1);
  end

endmodule

// File: rtl/present_ctrl.sv
// Sequencer for the iterative PRESENT-80 datapath: input handshake, load,
// 31 rounds, whitened-output capture, output handshake.
// Optional macro PRESENT_CTRL_ABORT_EN adds an 'abort' input that cancels a
// request in flight (LOAD/RUN/FIN) and returns to IDLE.
module present_ctrl
  import present_pkg::*;
#(
  parameter int ROUNDS = PRESENT_ROUNDS,
  parameter int RND_W  = CNT_W
) (
  input  logic             clk,
  input  logic             reset,
`ifdef PRESENT_CTRL_ABORT_EN
  input  logic             abort,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_plaintext,
  input  logic [KEY_W-1:0] in_key,
  output logic [BLK_W-1:0] dp_plaintext,
  output logic [KEY_W-1:0] dp_key,
  output logic             dp_load,
  output logic             dp_en,
  output logic [RND_W-1:0] dp_round,
  input  logic [BLK_W-1:0] dp_cipher,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             busy
);

  state_t           state, state_nxt;
  logic [RND_W-1:0] cnt;
  logic             last;
  logic             cnt_clr, cnt_ld1, cnt_inc;
  logic             capture;
  logic             abort_hit;

`ifdef PRESENT_CTRL_ABORT_EN
  // abort only matters while a request is in flight; IDLE/DONE ignore it
  assign abort_hit = abort && (state == LOAD || state == RUN || state == FIN);
`else
  assign abort_hit = 1'b0;
`endif

  present_round_cnt #(.ROUNDS(ROUNDS), .RND_W(RND_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .ld1   (cnt_ld1),
    .inc   (cnt_inc),
    .cnt   (cnt),
    .last  (last)
  );

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state and control decode; controls depend on state/counter only
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    dp_load   = 1'b0;
    dp_en     = 1'b0;
    dp_round  = '0;
    busy      = 1'b0;
    out_valid = 1'b0;
    cnt_clr   = 1'b0;
    cnt_ld1   = 1'b0;
    cnt_inc   = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        cnt_clr  = 1'b1;
        if (in_valid) state_nxt = LOAD;
      end
      LOAD: begin
        dp_load   = 1'b1;
        dp_en     = 1'b1;
        busy      = 1'b1;
        cnt_ld1   = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        dp_en    = 1'b1;
        dp_round = cnt;
        busy     = 1'b1;
        cnt_inc  = 1'b1;
        if (last) state_nxt = FIN;
      end
      FIN: begin
        busy      = 1'b1;
        capture   = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort_hit) begin
      state_nxt = IDLE;
      cnt_clr   = 1'b1;
      capture   = 1'b0;
    end
  end

  // request registers: held for the datapath until the next accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dp_plaintext <= '0;
      dp_key       <= '0;
    end else if (in_valid && in_ready) begin
      dp_plaintext <= in_plaintext;
      dp_key       <= in_key;
    end
  end

  // ciphertext capture after the final round
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       out_data <= '0;
    else if (capture) out_data <= dp_cipher;
  end

endmodule

// File: tb/tb_present_ctrl.sv
// Directed bench for present_ctrl with a behavioural PRESENT-80 round datapath.
module tb_present_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_plaintext = '0;
  logic [79:0] in_key = '0;
  logic [63:0] dp_plaintext;
  logic [79:0] dp_key;
  logic        dp_load, dp_en;
  logic [4:0]  dp_round;
  logic [63:0] dp_cipher;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        busy;
`ifdef PRESENT_CTRL_ABORT_EN
  logic        abort = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  present_ctrl dut (
    .clk          (clk),
    .reset        (rst_n),
`ifdef PRESENT_CTRL_ABORT_EN
    .abort        (abort),
`endif
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_plaintext (in_plaintext),
    .in_key       (in_key),
    .dp_plaintext (dp_plaintext),
    .dp_key       (dp_key),
    .dp_load      (dp_load),
    .dp_en        (dp_en),
    .dp_round     (dp_round),
    .dp_cipher    (dp_cipher),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .busy         (busy)
  );

  // ---------------- PRESENT-80 round datapath ----------------
  function automatic logic [3:0] sb(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
      4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
      4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
      4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
    endcase
  endfunction

  function automatic logic [63:0] sbox64(input logic [63:0] s);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = sb(s[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [63:0] player(input logic [63:0] s);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[(i == 63) ? 63 : ((i * 16) % 63)] = s[i];
    return r;
  endfunction

  function automatic logic [79:0] kupd(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] r;
    r = {k[18:0], k[79:19]};
    r[79:76] = sb(r[79:76]);
    r[19:15] = r[19:15] ^ rc;
    return r;
  endfunction

  logic [63:0] st = '0;
  logic [79:0] rk = '0;

  always @(posedge clk) begin
    if (dp_en) begin
      if (dp_load) begin
        st <= dp_plaintext;
        rk <= dp_key;
      end else begin
        st <= player(sbox64(st ^ rk[79:16]));
        rk <= kupd(rk, dp_round);
      end
    end
  end

  assign dp_cipher = st ^ rk[79:16];

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tests++;
    if ({out_valid, busy, dp_load, dp_en, dp_round} !== 9'd0) begin
      fails++; $display("FAIL reset_ctrl: got %b want 0", {out_valid, busy, dp_load, dp_en, dp_round});
    end
    tests++;
    if ({out_data, dp_plaintext, dp_key} !== 208'd0) begin
      fails++; $display("FAIL reset_data: got %h want 0", {out_data, dp_plaintext, dp_key});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_vector(input logic [63:0] pt, input logic [79:0] k,
                             input logic [63:0] exp, input string name, input int hold);
    int n;
    logic ok;
    logic [63:0] snap;
    @(negedge clk);
    in_plaintext = pt; in_key = k; in_valid = 1'b1; out_ready = 1'b0;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL %s idle_ready: got %b want 1", name, in_ready); end
    @(posedge clk); #1;
    // junk request while busy must be ignored
    in_plaintext = ~pt; in_key = ~k;
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      if (n == 10) begin
        tests++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
          fails++; $display("FAIL %s busy_run: busy=%b in_ready=%b want 1/0", name, busy, in_ready);
        end
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    tests++;
    if (n != 33) begin fails++; $display("FAIL %s latency: got %0d want 33", name, n); end
    tests++;
    if (out_data !== exp) begin fails++; $display("FAIL %s out_data: got %h want %h", name, out_data, exp); end
    tests++;
    if (dp_plaintext !== pt || dp_key !== k) begin
      fails++; $display("FAIL %s dp_hold: got %h/%h want %h/%h", name, dp_plaintext, dp_key, pt, k);
    end
    if (hold > 0) begin
      ok = 1'b1; snap = out_data;
      repeat (hold) begin
        @(posedge clk); #1;
        if (out_data !== snap || in_ready !== 1'b0 || out_valid !== 1'b1) ok = 1'b0;
      end
      tests++;
      if (!ok) begin fails++; $display("FAIL %s hold_stable: got unstable want stable %h", name, snap); end
    end
    out_ready = 1'b1;
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL %s ready_same_cycle: got %b want 0", name, in_ready); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL %s release: in_ready=%b out_valid=%b want 1/0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int acc[4];
    logic [63:0] res[4];
    int na, nr;
    na = 0; nr = 0;
    @(negedge clk);
    in_plaintext = '1; in_key = '1; in_valid = 1'b1; out_ready = 1'b1;
    for (int t = 0; t < 90; t++) begin
      if (t > 0) @(negedge clk);
      if (na == 2 && t > acc[1]) in_valid = 1'b0;
      if (in_ready && in_valid && na < 4) begin acc[na] = t; na++; end
      if (out_valid && nr < 4) begin res[nr] = out_data; nr++; end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    tests++;
    if (na != 2 || nr != 2) begin fails++; $display("FAIL b2b_count: got %0d acc %0d res want 2/2", na, nr); end
    else begin
      tests++;
      if (acc[1] - acc[0] != 35) begin fails++; $display("FAIL b2b_spacing: got %0d want 35", acc[1] - acc[0]); end
      tests++;
      if (res[0] !== 64'h3333DCD3213210D2 || res[1] !== 64'h3333DCD3213210D2) begin
        fails++; $display("FAIL b2b_data: got %h %h want 3333dcd3213210d2", res[0], res[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic seen;
    @(negedge clk);
    in_plaintext = 64'h0123456789ABCDEF; in_key = 80'h1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (dp_round !== 5'd12 && n < 50) begin @(posedge clk); #1; n++; end
    tests++;
    if (dp_round !== 5'd12) begin fails++; $display("FAIL rst_mid_reach: got %0d want 12", dp_round); end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({in_ready, out_valid, busy, dp_load, dp_en, dp_round} !== 10'b1_0000_00000) begin
      fails++; $display("FAIL rst_mid_ctrl: got %b want 1000000000", {in_ready, out_valid, busy, dp_load, dp_en, dp_round});
    end
    tests++;
    if ({out_data, dp_plaintext, dp_key} !== 208'd0) begin
      fails++; $display("FAIL rst_mid_data: got %h want 0", {out_data, dp_plaintext, dp_key});
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    tests++;
    if (seen) begin fails++; $display("FAIL rst_mid_no_valid: got pulse want none"); end
    test_vector(64'h0, 80'h0, 64'h5579C1387B228445, "post_reset", 0);
  endtask

`ifdef PRESENT_CTRL_ABORT_EN
  task automatic test_abort();
    int n;
    logic seen;
    @(negedge clk);
    in_plaintext = '0; in_key = '0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (dp_round !== 5'd20 && n < 50) begin @(posedge clk); #1; n++; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL abort_run: in_ready=%b out_valid=%b busy=%b want 1/0/0", in_ready, out_valid, busy);
    end
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    tests++;
    if (seen) begin fails++; $display("FAIL abort_no_valid: got pulse want none"); end
    // abort while DONE is ignored
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_data !== 64'h5579C1387B228445) begin
      fails++; $display("FAIL abort_done: out_valid=%b data=%h want 1/5579c1387b228445", out_valid, out_data);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_vector(64'h0, 80'h0, 64'h5579C1387B228445, "p0_k0", 0);
    test_vector(64'h0, {80{1'b1}}, 64'hE72C46C0F5945049, "p0_k1", 0);
    test_vector({64{1'b1}}, 80'h0, 64'hA112FFC72F68417B, "p1_k0_hold", 10);
    test_back_to_back();
    test_reset_mid();
`ifdef PRESENT_CTRL_ABORT_EN
    test_abort();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/present_ctrl.md
# present_ctrl

Sequencer for the iterative PRESENT-80 round datapath: one mux/register/S-box/P-layer/key-update loop plus its round counter. It accepts a plaintext/key pair over a valid/ready handshake and holds them stable for the datapath. It then drives the datapath load select, register enable and round index through all 31 rounds. Finally it captures the whitened ciphertext and presents it over a second valid/ready handshake.

## Interface
- `ROUNDS`, 31: number of full rounds; the counter runs 1..`ROUNDS`.
- `RND_W`, 5: width of the round index.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `in_valid` input 1: request carries a plaintext/key pair.
- `in_ready` output 1: block can accept a request.
- `in_plaintext` input 64: plaintext, sampled on accept.
- `in_key` input 80: key, sampled on accept.
- `dp_plaintext` output 64: registered plaintext driven to the datapath mux.
- `dp_key` output 80: registered key driven to the key mux.
- `dp_load` output 1: datapath mux selects `dp_plaintext`/`dp_key`; the datapath's existing mux select.
- `dp_en` output 1: datapath state/key registers update this edge.
- `dp_round` output 5: round index for the key-update round constant.
- `dp_cipher` input 64: datapath state XOR round key (whitened output).
- `out_valid` output 1: `out_data` holds a ciphertext.
- `out_ready` input 1: consumer takes the ciphertext.
- `out_data` output 64: captured ciphertext.
- `busy` output 1: high in LOAD, RUN and FIN.

## Operation
- **States.** IDLE, LOAD, RUN, FIN, DONE.
- **IDLE.**
  - `in_ready`=1.
  - Accept on `in_valid && in_ready`: register `in_plaintext`/`in_key` into `dp_plaintext`/`dp_key`, then go to LOAD.
- **LOAD.**
  - Drive `dp_load`=1, `dp_en`=1, `dp_round`=0.
  - On the edge the datapath registers load P and K, and the round counter is set to 1. Go to RUN.
- **RUN.**
  - Drive `dp_load`=0, `dp_en`=1, `dp_round`=counter.
  - The counter increments each edge. When counter==`ROUNDS`, that edge executes the final round and the state goes to FIN.
- **FIN.**
  - Drive `dp_en`=0.
  - `out_data` <= `dp_cipher` (state after round 31 XOR K32). Go to DONE.
- **DONE.**
  - `out_valid`=1; `out_data` stays stable.
  - On `out_ready`, go to IDLE.
- **Overlap and hold.**
  - No request is accepted outside IDLE.
  - `dp_plaintext`/`dp_key` hold their value until the next accept.
- **Counter.** 5-bit and never wraps. It is cleared to 0 in IDLE, and values above `ROUNDS` are unreachable.
- **Control outputs.** `dp_load`, `dp_en` and `dp_round` are decoded from registered state and counter only; there is no combinational path from `in_valid`.

## Timing
- **Reset values.** While `reset`=0: state=IDLE, counter=0, `in_ready`=1, and all other outputs 0, including `out_data`, `dp_plaintext` and `dp_key`.
- **Reset mid-operation.** Returns to IDLE immediately; the result is discarded and no `out_valid` pulse follows.
- **Latency.**
  - Accept at edge N, then LOAD during cycle N+1.
  - Rounds 1..31 execute at edges N+2..N+32.
  - Capture at edge N+33; `out_valid` is high from edge N+33.
  - Minimum accept-to-accept spacing is 35 edges when `out_ready` is held high.
- **Simultaneous events.**
  - `out_ready` high in DONE: `in_ready` rises the next cycle, not the same cycle.
  - `in_valid` while busy: ignored, no back-pressure violation, because `in_ready`=0.
  - `out_ready` before DONE: ignored.

## Configuration
- `PRESENT_CTRL_ABORT_EN` defined: adds input `abort` (1 bit).
  - `abort`=1 in LOAD, RUN or FIN forces IDLE at the next edge and clears the counter; `out_valid` does not rise for that request.
  - `abort` is ignored in IDLE and DONE.
  - `abort` together with an accept in IDLE: the accept wins.
- `PRESENT_CTRL_ABORT_EN` undefined: no `abort` port; every accepted request runs to DONE.

## Structure
- **Package `present_pkg`:**
  - state enum (IDLE, LOAD, RUN, FIN, DONE);
  - `PRESENT_ROUNDS`=31;
  - widths 64 / 80 / 5.
- **Sub-module `present_round_cnt`:** holds the round counter, with clear, load-1 and increment inputs and a `last` flag (counter==`ROUNDS`).
- **Top FSM:** the handshake registers and the FSM live in `present_ctrl`.

## Test plan
Each case runs with the real round datapath attached.
- Plaintext 0, key 0 -> `out_data`=5579C1387B228445, `out_valid` exactly 33 edges after accept.
- Plaintext 0, key FFFFFFFFFFFFFFFFFFFF -> E72C46C0F5945049.
- Plaintext FFFFFFFFFFFFFFFF, key 0 -> A112FFC72F68417B. `out_ready` held low for 10 cycles: `out_data` stable and `in_ready`=0 throughout.
- Plaintext and key all-ones -> 3333DCD3213210D2, submitted back-to-back with `out_ready`=1: two results; second accept 35 edges after the first.
- **Reset mid-run:** `reset` low at round 12 -> all outputs 0 and state IDLE. A fresh request with plaintext 0, key 0 then yields 5579C1387B228445.
- **Abort (`PRESENT_CTRL_ABORT_EN`):** `abort` at round 20 -> no `out_valid`, `in_ready`=1 the next cycle. `abort` in DONE has no effect.
